mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//  MEM stage of the 5-stage MIPS pipeline: sits between EX/MEM and MEM/WB registers.
//  Runs loads/stores to data memory over a variable-latency req/ack bus, stalls upstream
//  stages until the access completes, and presents WB_EN/MEM_R_EN/read_data/ALUresult/Dest
//  to MEM/WB. Non-memory instructions pass through with zero added latency.
// PARAMETERS
//  ADDR_W          32  data-memory byte address width
//  DATA_W          32  data word width
//  TIMEOUT_CYCLES  15  max BUSY cycles awaiting mem_ack before bus error; 0 disables timeout
// PORTS
//  clk            in   1       pipeline clock, rising edge
//  rst_n          in   1       asynchronous, active-low reset
//  WB_EN          in   1       from EX/MEM: instruction writes register file
//  MEM_R_EN       in   1       from EX/MEM: load
//  MEM_W_EN       in   1       from EX/MEM: store
//  ALUresult      in   ADDR_W  from EX/MEM: effective address / ALU value
//  store_data     in   DATA_W  from EX/MEM: store operand
//  Dest           in   5       from EX/MEM: destination register
//  WB_EN_out      out  1       to MEM/WB; 0 while stalled (bubble)
//  MEM_R_EN_out   out  1       to MEM/WB; 0 while stalled
//  read_data_out  out  DATA_W  to MEM/WB: load data
//  ALUresult_out  out  ADDR_W  to MEM/WB: ALUresult passed through
//  Dest_out       out  5       to MEM/WB: Dest passed through
//  stall          out  1       freeze PC, IF/ID, ID/EX, EX/MEM
//  mem_req        out  1       bus request, registered
//  mem_we         out  1       bus write strobe, registered
//  mem_addr       out  ADDR_W  {ALUresult[ADDR_W-1:2],2'b00}, registered
//  mem_wdata      out  DATA_W  store_data, registered
//  mem_rdata      in   DATA_W  bus read data, valid with mem_ack
//  mem_ack        in   1       bus completion, single-cycle pulse
//  bus_err        out  1       one-cycle pulse on timeout
// BEHAVIOUR
//  Reset (async): state=IDLE, mem_req/mem_we/bus_err=0, mem_addr/mem_wdata=0,
//   read_data register=0, timeout counter=0. Reset mid-access drops mem_req immediately;
//   any later mem_ack is ignored.
//  FSM IDLE -> BUSY -> DONE -> IDLE:
//   IDLE: access = MEM_R_EN|MEM_W_EN. If access: stall=1 combinationally, register
//    mem_req=1, mem_we=MEM_W_EN, mem_addr, mem_wdata; go BUSY. Otherwise stall=0 and
//    outputs pass inputs through combinationally; read_data_out=0.
//   BUSY: stall=1; mem_req, mem_we, mem_addr, mem_wdata held stable. On mem_ack: capture
//    mem_rdata (reads only), clear mem_req, go DONE. Counter increments each BUSY cycle
//    without ack; reaching TIMEOUT_CYCLES: bus_err pulses, mem_req clears, capture 0,
//    mark error, go DONE. mem_ack and timeout in the same cycle: ack wins, no bus_err.
//   DONE: stall=0; outputs = held inputs; read_data_out=captured word. If the access
//    errored, WB_EN_out=0. Next state is always IDLE; the next instruction is evaluated
//    the following cycle. Back-to-back memory ops therefore cost >=3 cycles each.
//  While stall=1: WB_EN_out=0, MEM_R_EN_out=0; Dest/ALUresult outputs are don't-care.
//  Latency: ack in cycle k -> data on read_data_out in cycle k+1; MEM/WB captures it at
//   the end of cycle k+1. Minimum access is 3 cycles (IDLE, BUSY w/ ack, DONE).
//  mem_ack outside BUSY is ignored. MEM_R_EN&MEM_W_EN both set: store wins, read_data=0.
//  Address low bits [1:0] are dropped on the bus (word access only). No alignment trap.
//  Counter width $clog2(TIMEOUT_CYCLES+1); it saturates, never wraps. It clears on IDLE.
// STRUCTURE
//  Shared package mips_pkg: mem_state_t enum {IDLE,BUSY,DONE}, DATA_W/ADDR_W constants,
//   REG_ADDR_W=5.
//  One sub-module: mem_timeout_ctr (clear, enable, TIMEOUT_CYCLES param, expired output).
// TESTING
//  Pass-through: ALU op WB_EN=1,ALUresult=0x1234,Dest=7 -> same cycle outputs equal, stall=0.
//  Load, ack after 2 BUSY cycles, mem_rdata=0xCAFEF00D, addr=0x103 -> mem_addr=0x100,
//   stall 3 cycles, read_data_out=0xCAFEF00D in DONE with WB_EN_out=1.
//  Store addr=0x40,data=0xA5A5A5A5 -> mem_we=1, wdata stable until ack, WB_EN_out=0 throughout.
//  No ack, TIMEOUT_CYCLES=4 -> bus_err pulses after 4 BUSY cycles, read_data_out=0,
//   WB_EN_out=0 in DONE, then IDLE.
//  Ack on the exact expiry cycle -> data captured, no bus_err.
//  rst_n low during BUSY -> mem_req=0 immediately; stray ack after release ignored; state IDLE.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and widths for the MIPS pipeline stages.
package mips_pkg;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Saturating up-counter that flags when a bus access has waited too long.
module mem_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  // Fires during the wait cycle that would bring the count up to the limit.
  assign expired = (TIMEOUT_CYCLES != 0) && enable &&
                   ((int'(count) + 1) >= TIMEOUT_CYCLES);

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: runs loads/stores over a req/ack bus, stalls upstream until done.
//  state | meaning
//  IDLE  | pass-through; a load/store launches the bus request
//  BUSY  | request outstanding, waiting for mem_ack or timeout
//  DONE  | present the finished access to MEM/WB for one cycle
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int ADDR_W         = mips_pkg::ADDR_W,
  parameter int DATA_W         = mips_pkg::DATA_W,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  WB_EN,
  input  logic                  MEM_R_EN,
  input  logic                  MEM_W_EN,
  input  logic [ADDR_W-1:0]     ALUresult,
  input  logic [DATA_W-1:0]     store_data,
  input  logic [REG_ADDR_W-1:0] Dest,
  output logic                  WB_EN_out,
  output logic                  MEM_R_EN_out,
  output logic [DATA_W-1:0]     read_data_out,
  output logic [ADDR_W-1:0]     ALUresult_out,
  output logic [REG_ADDR_W-1:0] Dest_out,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack,
  output logic                  bus_err
);

  mem_state_t state;

  logic                  access;
  logic                  expired;
  logic                  hold_wb;
  logic                  hold_mr;
  logic                  hold_mw;
  logic                  hold_err;
  logic [ADDR_W-1:0]     hold_alu;
  logic [REG_ADDR_W-1:0] hold_dest;
  logic [DATA_W-1:0]     rdata_q;

  assign access = MEM_R_EN | MEM_W_EN;

  mem_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == IDLE),
    .enable  ((state == BUSY) && !mem_ack),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      bus_err   <= 1'b0;
      rdata_q   <= '0;
      hold_wb   <= 1'b0;
      hold_mr   <= 1'b0;
      hold_mw   <= 1'b0;
      hold_err  <= 1'b0;
      hold_alu  <= '0;
      hold_dest <= '0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            mem_req   <= 1'b1;
            mem_we    <= MEM_W_EN;
            mem_addr  <= {ALUresult[ADDR_W-1:2], 2'b00};
            mem_wdata <= store_data;
            hold_wb   <= WB_EN;
            hold_mr   <= MEM_R_EN;
            hold_mw   <= MEM_W_EN;
            hold_alu  <= ALUresult;
            hold_dest <= Dest;
            hold_err  <= 1'b0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          // An ack in the expiry cycle takes priority over the timeout.
          if (mem_ack) begin
            rdata_q <= (hold_mr && !hold_mw) ? mem_rdata : '0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= DONE;
          end else if (expired) begin
            rdata_q  <= '0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            bus_err  <= 1'b1;
            hold_err <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    stall         = 1'b0;
    WB_EN_out     = WB_EN;
    MEM_R_EN_out  = MEM_R_EN;
    read_data_out = '0;
    ALUresult_out = ALUresult;
    Dest_out      = Dest;
    case (state)
      IDLE: begin
        if (access) begin
          stall        = 1'b1;
          WB_EN_out    = 1'b0;
          MEM_R_EN_out = 1'b0;
        end
      end
      BUSY: begin
        stall         = 1'b1;
        WB_EN_out     = 1'b0;
        MEM_R_EN_out  = 1'b0;
        ALUresult_out = hold_alu;
        Dest_out      = hold_dest;
      end
      DONE: begin
        WB_EN_out     = hold_wb & ~hold_err;
        MEM_R_EN_out  = hold_mr;
        read_data_out = rdata_q;
        ALUresult_out = hold_alu;
        Dest_out      = hold_dest;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

endmodule
